// File: rtl/segment_pkg.sv
// segment_pkg: shared types and the hex-to-seven-segment table for the display scanner.
// Cathode patterns are active-low, bit order {g,f,e,d,c,b,a}.
package segment_pkg;

    localparam int DIGITS_DEF = 8;

    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {BLANK, SHOW} scan_state_e;

    typedef enum logic {OWN_QUEUE, OWN_OVERLAY} owner_e;

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: hex nibble to active-low {g,f,e,d,c,b,a} cathode pattern.
module seg_hex_decode
    import segment_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter: multiplexed seven-segment scanner with frame-aligned queue/overlay ownership.
// Define SEG_DIM_EN to add the 3-bit dim input (PWM within the lit part of each slot).
module seg_scan_arbiter
    import segment_pkg::*;
#(
    parameter int DIGITS      = DIGITS_DEF,
    parameter int SCAN_DIV    = 14637,
    parameter int BLANK_CYC   = 1024,
    parameter int HOLD_FRAMES = 64
) (
    input  logic                       Origin_Clock,
    input  logic                       reset,
    input  logic [4*DIGITS-1:0]        q_data,
    input  logic [DIGITS-1:0]          q_mask,
    input  logic [DIGITS-1:0]          q_dp,
    input  logic                       ov_req,
    input  logic [4*DIGITS-1:0]        ov_data,
    input  logic [DIGITS-1:0]          ov_mask,
`ifdef SEG_DIM_EN
    input  logic [2:0]                 dim,
`endif
    output logic                       ov_grant,
    output logic                       frame_start,
    output logic [$clog2(DIGITS)-1:0]  digit_idx,
    output logic [DIGITS-1:0]          an,
    output logic [6:0]                 seg,
    output logic                       dp
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DIGITS);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    logic [PW-1:0]       presc_q, presc_d;
    logic [DW-1:0]       digit_q, digit_d;
    scan_state_e         state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [4*DIGITS-1:0] data_q, data_d;
    logic [DIGITS-1:0]   mask_q, mask_d, dpm_q, dpm_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d, seg_hex;
    logic                dp_q, dp_d, fs_q, fs_d;
    logic                wrap, boundary, to_ov, show, bright;

    assign wrap     = presc_q == PW'(SCAN_DIV - 1);
    assign boundary = wrap && digit_q == DW'(DIGITS - 1);
    assign show     = state_q == SHOW;

    always_comb begin
        presc_d = wrap ? '0 : presc_q + PW'(1);
        digit_d = wrap ? digit_q + DW'(1) : digit_q;
        state_d = wrap ? BLANK : (presc_q == PW'(BLANK_CYC - 1)) ? SHOW : state_q;
        owner_d = !boundary ? owner_q
                : (owner_q == OWN_QUEUE) ? (ov_req ? OWN_OVERLAY : OWN_QUEUE)
                : (hold_q != '0 || ov_req) ? OWN_OVERLAY : OWN_QUEUE;
        hold_d  = !boundary ? hold_q
                : (owner_q == OWN_QUEUE && ov_req) ? HW'(HOLD_FRAMES - 1)
                : (owner_q == OWN_OVERLAY && hold_q != '0) ? hold_q - HW'(1) : hold_q;
    end

    // Snapshot comes from whichever source wins this boundary; the overlay never lights dp.
    assign to_ov  = owner_d == OWN_OVERLAY;
    assign data_d = boundary ? (to_ov ? ov_data : q_data) : data_q;
    assign mask_d = boundary ? (to_ov ? ov_mask : q_mask) : mask_q;
    assign dpm_d  = boundary ? (to_ov ? '0 : q_dp) : dpm_q;

    seg_hex_decode u_dec (
        .nibble_i (data_q[{digit_q, 2'b00} +: 4]),
        .seg_o    (seg_hex)
    );

`ifdef SEG_DIM_EN
    logic [2:0] dim_q, dim_d;
    assign dim_d  = boundary ? dim : dim_q;
    assign bright = 3'((presc_q - PW'(BLANK_CYC)) >> (PW - 3)) >= dim_q;
`else
    assign bright = 1'b1;
`endif

    assign an_d  = (show && mask_q[digit_q] && bright) ? ~(DIGITS'(1) << digit_q) : '1;
    assign seg_d = show ? seg_hex : 7'h7F;
    assign dp_d  = !(show && dpm_q[digit_q]);
    assign fs_d  = boundary;

    always_ff @(posedge Origin_Clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            digit_q <= '0;
            state_q <= BLANK;
            owner_q <= OWN_QUEUE;
            hold_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            dpm_q   <= '0;
            an_q    <= '1;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            fs_q    <= 1'b0;
`ifdef SEG_DIM_EN
            dim_q   <= '0;
`endif
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            dpm_q   <= dpm_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fs_q    <= fs_d;
`ifdef SEG_DIM_EN
            dim_q   <= dim_d;
`endif
        end
    end

    assign ov_grant    = owner_q == OWN_OVERLAY;
    assign frame_start = fs_q;
    assign digit_idx   = digit_q;
    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;

endmodule
